// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Two-master round-robin arbiter for the native memory bus, with
//            CPU hold for boot loading and a per-transfer timeout watchdog.
// Revision : 1.0
// ============================================================================
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    input  logic        cpu_hold,
    input  logic        err_clr,
    output logic        err,
    output logic        err_master
);

    localparam logic [0:0]  IDLE     = 1'b0;
    localparam logic [0:0]  BUSY     = 1'b1;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [0:0]  state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        err_master_q, err_master_d;

    logic        busy;
    logic        req0;
    logic        req1;
    logic        timeout;
    logic        done;
    logic [31:0] rdata_sel;

    // Outputs are gated by rst so nothing leaks while reset is held mid-transfer.
    always_comb begin
        busy      = (state_q == BUSY) && !rst;
        req0      = m0_valid && !cpu_hold;
        req1      = m1_valid;
        timeout   = busy && !s_ready && (cnt_q == CNT_LAST);
        done      = busy && (s_ready || timeout);
        rdata_sel = timeout ? ERR_RDATA : s_rdata;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    grant_d = (req0 && req1) ? ~last_q : req1;
                end
            end
            default: begin
                if (done) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        endcase
        // A timeout in the same cycle as err_clr keeps the flag set.
        err_d        = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
        err_master_d = timeout ? grant_q : err_master_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            err_master_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            err_master_q <= err_master_d;
        end
    end

    assign s_valid    = busy;
    assign s_addr     = busy ? (grant_q ? m1_addr  : m0_addr)  : '0;
    assign s_wdata    = busy ? (grant_q ? m1_wdata : m0_wdata) : '0;
    assign s_wstrb    = busy ? (grant_q ? m1_wstrb : m0_wstrb) : '0;
    assign m0_ready   = done && !grant_q;
    assign m1_ready   = done && grant_q;
    assign m0_rdata   = (busy && !grant_q) ? rdata_sel : '0;
    assign m1_rdata   = (busy && grant_q)  ? rdata_sel : '0;
    assign err        = err_q && !rst;
    assign err_master = err_master_q && !rst;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed and randomized self-checking bench for mem_bus_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int          T    = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m1_valid, m0_ready, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        s_valid, s_ready, cpu_hold, err_clr, err, err_master;
    logic [31:0] s_addr, s_wdata, s_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERRD)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .cpu_hold(cpu_hold), .err_clr(err_clr), .err(err), .err_master(err_master)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // Reference model: which master currently owns the bus, how long it has waited,
    // who was served last, and the sticky error flag.
    bit mb_busy, nb_busy;
    int mb_own, nb_own, mb_wait, nb_wait, mb_last, nb_last;
    bit me_err, ne_err, me_errm, ne_errm;
    bit e_r0, e_r1;
    bit sram_mode, prev_sv, prev_sr, dead;
    int other_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        bit r0, r1, to, fin;
        logic        e_sv;
        logic [31:0] e_addr, e_wdata, e_d0, e_d1, rdv;
        logic [3:0]  e_wstrb;
        if (sram_mode) s_ready = prev_sv & ~prev_sr;
        #2;
        e_sv = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
        e_r0 = 0; e_r1 = 0; e_d0 = 0; e_d1 = 0; to = 0;
        nb_busy = mb_busy; nb_own = mb_own; nb_wait = mb_wait; nb_last = mb_last;
        ne_err = me_err; ne_errm = me_errm;
        if (rst) begin
            nb_busy = 0; nb_last = 1; nb_wait = 0; ne_err = 0; ne_errm = 0;
        end else if (!mb_busy) begin
            r0 = m0_valid && !cpu_hold;
            r1 = m1_valid;
            if (r0 || r1) begin
                nb_busy = 1;
                nb_wait = 0;
                nb_own  = (r0 && r1) ? 1 - mb_last : (r1 ? 1 : 0);
            end
        end else begin
            e_sv    = 1;
            e_addr  = (mb_own == 1) ? m1_addr  : m0_addr;
            e_wdata = (mb_own == 1) ? m1_wdata : m0_wdata;
            e_wstrb = (mb_own == 1) ? m1_wstrb : m0_wstrb;
            to  = !s_ready && (mb_wait == T - 1);
            fin = s_ready || to;
            rdv = to ? ERRD : s_rdata;
            if (mb_own == 1) begin e_r1 = fin; e_d1 = rdv; end
            else begin e_r0 = fin; e_d0 = rdv; end
            if (fin) begin nb_busy = 0; nb_last = mb_own; end
            else nb_wait = mb_wait + 1;
            if (to) ne_errm = (mb_own == 1);
        end
        if (!rst) ne_err = to ? 1'b1 : (err_clr ? 1'b0 : me_err);
        chk("s_valid", s_valid, e_sv);
        chk("s_addr", s_addr, e_addr);
        chk("s_wdata", s_wdata, e_wdata);
        chk("s_wstrb", s_wstrb, e_wstrb);
        chk("m0_ready", m0_ready, e_r0);
        chk("m1_ready", m1_ready, e_r1);
        chk("m0_rdata", m0_rdata, e_d0);
        chk("m1_rdata", m1_rdata, e_d1);
        chk("err", err, rst ? 1'b0 : me_err);
        chk("err_master", err_master, rst ? 1'b0 : me_errm);
        prev_sv = s_valid;
        prev_sr = s_ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mb_busy = nb_busy; mb_own = nb_own; mb_wait = nb_wait; mb_last = nb_last;
        me_err = ne_err; me_errm = ne_errm;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    // Runs cycles until master mi is readied; returns after the check phase of that cycle.
    task automatic run_until(input int mi, input int budget, input int sr_at,
                             output int nb, output bit ok);
        nb = 0; ok = 0; other_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            if (sr_at >= 0) s_ready = (nb == sr_at);
            settle();
            if (s_valid) nb++;
            if ((mi == 0) ? m0_ready : m1_ready) begin
                ok = 1;
                return;
            end
            if ((mi == 0) ? m1_ready : m0_ready) other_cnt++;
            tick();
        end
    endtask

    task automatic new_m0();
        m0_addr = $urandom & 32'hFFFF_FFFC; m0_wdata = $urandom; m0_wstrb = 4'($urandom);
    endtask

    task automatic new_m1();
        m1_addr = $urandom & 32'hFFFF_FFFC; m1_wdata = $urandom; m1_wstrb = 4'($urandom);
    endtask

    initial begin
        int nb;
        bit ok, d0, d1;
        rst = 1; m0_valid = 0; m1_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_addr = 0; m1_wdata = 0; m1_wstrb = 0; s_ready = 0; s_rdata = 0;
        cpu_hold = 0; err_clr = 0; sram_mode = 0; prev_sv = 0; prev_sr = 0; dead = 0;
        mb_busy = 0; mb_own = 0; mb_wait = 0; mb_last = 1; me_err = 0; me_errm = 0;
        #1;
        cyc(); cyc();
        rst = 0;

        // Single CPU read through a 1-cycle slave
        sram_mode = 1; s_rdata = 32'h1234_5678;
        m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 0;
        settle(); chk("t1_sv_N", s_valid, 0); tick();
        settle(); chk("t1_sv_N1", s_valid, 1); chk("t1_rdy_N1", m0_ready, 0); tick();
        settle(); chk("t1_rdy_N2", m0_ready, 1); chk("t1_rdata", m0_rdata, 32'h1234_5678);
        chk("t1_m1rdy", m1_ready, 0); tick();
        m0_valid = 0; cyc();

        // Contention from reset alternates m0, m1, m0, m1
        m0_valid = 1; m0_addr = 32'h100; m0_wdata = 32'hA0A0_A0A0; m0_wstrb = 4'hF;
        m1_valid = 1; m1_addr = 32'h200; m1_wdata = 32'h5;         m1_wstrb = 4'h3;
        rst = 1; cyc(); cyc(); rst = 0;
        for (int k = 0; k < 4; k++) begin
            run_until(k % 2, 20, -1, nb, ok);
            chk("t2_served", ok, 1);
            chk("t2_other", other_cnt, 0);
            chk("t2_addr", s_addr, (k % 2 == 1) ? 32'h200 : 32'h100);
            chk("t2_wstrb", s_wstrb, (k % 2 == 1) ? 4'h3 : 4'hF);
            tick();
        end
        m0_valid = 0; m1_valid = 0; cyc(); cyc();

        // cpu_hold lets only the loader through, then m0 wins once released
        cpu_hold = 1; m0_valid = 1; m0_addr = 32'h300; m0_wstrb = 0;
        m1_valid = 1; m1_wstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            m1_addr = 32'(k * 4); m1_wdata = $urandom;
            run_until(1, 20, -1, nb, ok);
            chk("t3_served", ok, 1);
            chk("t3_m0_blocked", other_cnt, 0);
            chk("t3_addr", s_addr, 32'(k * 4));
            tick();
        end
        cpu_hold = 0; m1_addr = 32'h10;
        run_until(0, 20, -1, nb, ok);
        chk("t3_m0_next", ok, 1);
        chk("t3_m1_not_first", other_cnt, 0);
        tick();
        m0_valid = 0; m1_valid = 0; cyc(); cyc();

        // Dead slave: loader read times out on its 8th bus cycle
        sram_mode = 0; s_ready = 0; s_rdata = 32'h0BAD_0BAD;
        m1_valid = 1; m1_addr = 32'h400; m1_wstrb = 0;
        run_until(1, 30, -1, nb, ok);
        chk("t4_timeout", ok, 1);
        chk("t4_lat", nb, T);
        chk("t4_rdata", m1_rdata, ERRD);
        tick();
        m1_valid = 0;
        settle(); chk("t4_err", err, 1); chk("t4_errm", err_master, 1); tick();
        err_clr = 1; cyc(); err_clr = 0;
        settle(); chk("t4_clr", err, 0); tick();

        // s_ready on the last allowed cycle completes normally
        s_rdata = 32'hCAFE_0001; m0_valid = 1; m0_addr = 32'h500; m0_wstrb = 0;
        run_until(0, 30, T - 1, nb, ok);
        chk("t5_done", ok, 1);
        chk("t5_lat", nb, T);
        chk("t5_rdata", m0_rdata, 32'hCAFE_0001);
        tick();
        s_ready = 0; m0_valid = 0;
        settle(); chk("t5_noerr", err, 0); tick();

        // Timeout coinciding with err_clr leaves err set
        err_clr = 1; m0_valid = 1;
        run_until(0, 30, -1, nb, ok);
        chk("t6_timeout", ok, 1);
        chk("t6_rdata", m0_rdata, ERRD);
        tick();
        err_clr = 0; m0_valid = 0;
        settle(); chk("t6_err_set", err, 1); chk("t6_errm", err_master, 0); tick();

        // Reset one cycle into a granted transfer
        m0_valid = 1; m0_addr = 32'h600;
        cyc();
        settle(); chk("t7_busy", s_valid, 1); tick();
        rst = 1; s_ready = 1; m1_valid = 1;
        settle(); chk("t7_rst_rdy", m0_ready, 0); tick();
        rst = 0; s_ready = 0;
        settle(); chk("t7_sv", s_valid, 0); chk("t7_r0", m0_ready, 0);
        chk("t7_r1", m1_ready, 0); chk("t7_err", err, 0); tick();
        sram_mode = 1;
        run_until(0, 20, -1, nb, ok);
        chk("t7_m0_first", ok, 1);
        chk("t7_m1_wait", other_cnt, 0);
        tick();
        m0_valid = 0; m1_valid = 0; sram_mode = 0; cyc(); cyc();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dead = ($urandom % 3 == 0);
            if (i % 40 == 0) cpu_hold = ($urandom % 3 == 0);
            rst = ($urandom % 500 == 0);
            err_clr = ($urandom % 8 == 0);
            s_ready = dead ? 1'b0 : ($urandom % 3 == 0);
            s_rdata = $urandom;
            if (!m0_valid && ($urandom % 4 == 0)) begin new_m0(); m0_valid = 1; end
            if (!m1_valid && ($urandom % 4 == 0)) begin new_m1(); m1_valid = 1; end
            settle();
            d0 = e_r0; d1 = e_r1;
            tick();
            if (d0) begin m0_valid = $urandom % 2; new_m0(); end
            if (d1) begin m1_valid = $urandom % 2; new_m1(); end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
